icache_dm: RTL and testbench
============================

# icache_dm

Direct-mapped, parameterised instruction cache replacing the fixed-content instruction ROM between the fetch buffer (FB) and the lower memory level. It serves FB line requests from a NUM_SETS-entry tag/data array and refills misses from memory through a blocking, single-outstanding-miss FSM. It adds ready backpressure toward FB, a whole-cache flush, and saturating hit/miss counters. Request and response use the existing mem_common request/response types.

## Interface
- NUM_SETS, 64: number of lines; power of two, at least 2.
- CNT_W, 32: width of the performance counters.
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-high.
- fb_ic_req_nnn  in  t_mem_req  FB line request (valid, id, addr).
- ic_fb_rdy_nnn  out  1  request accepted this cycle when valid & rdy.
- ic_fb_rsp_nnn  out  t_mem_rsp  line response (valid, id, data.W[CL_SZ_WORDS]); FB always accepts it.
- ic_mem_req_nnn  out  t_mem_req  refill request to memory, one-cycle valid pulse.
- mem_ic_rsp_nnn  in  t_mem_rsp  refill data; first valid after the request is the fill.
- ic_flush_nnn  in  1  invalidate all lines.
- ic_hit_cnt  out  CNT_W  saturating count of accepted hits.
- ic_miss_cnt  out  CNT_W  saturating count of accepted misses.

## Operation
- Address split: OFF_W = clog2(CL_SZ_WORDS*4); IDX_W = clog2(NUM_SETS); the tag is the remaining upper addr bits. Word offset bits are ignored and the line is always returned whole.
- Per set: a valid bit in flops, a tag, and a line of CL_SZ_WORDS words.
- FSM states: RUN, MISS_REQ, MISS_WAIT, FILL.
- RUN: ic_fb_rdy = ~ic_flush. On accept, compare the tag and valid bit of set[idx].
  - Hit: register the response. The hit counter increments.
  - Miss: latch id, idx, tag and the line-aligned addr. Go to MISS_REQ. The miss counter increments.
- MISS_REQ: drive ic_mem_req valid for one cycle with the latched id and the aligned addr. Go to MISS_WAIT. rdy=0.
- MISS_WAIT: wait for mem_ic_rsp.valid. On it, write data into set[idx] and set the tag. Set valid unless poisoned. Go to FILL. rdy=0.
- FILL: drive ic_fb_rsp valid with the latched id and the filled data. Clear poison. Return to RUN. rdy=0.
- Flush:
  - Clears every valid bit at the next edge, in all states.
  - A flush asserted in MISS_REQ or MISS_WAIT sets poison: the fill still returns its data to FB but leaves the line invalid.
  - A flush coinciding with the mem response cycle also poisons.
  - rdy is forced low during flush, so a request and a flush never coincide.
- Counters saturate at all-ones and do not wrap.
- Only the first mem response after a request counts; an unsolicited mem_ic_rsp in RUN is ignored (SIMULATION assertion).

## Timing
- Hit latency: request accepted at edge N, ic_fb_rsp valid in cycle N+1.
- Back-to-back hits: one per cycle.
- Miss sequence:
  - Accept at N: state moves to MISS_REQ.
  - ic_mem_req valid in cycle N+1.
  - mem response in cycle M ≥ N+2.
  - ic_fb_rsp valid in cycle M+1.
  - rdy returns high in cycle M+2.
- rdy is low from cycle N+1 through M+1.
- ic_fb_rsp and ic_mem_req are registered. rdy is combinational from state and ic_flush only, with no dependence on request valid.
- Reset (async assert) sets:
  - state RUN, all valid bits 0, poison 0;
  - ic_fb_rsp.valid 0, ic_mem_req.valid 0;
  - counters 0; rdy 1 (when flush is low).
- Reset asserted mid-miss abandons the miss. A late mem response after reset deasserts is ignored in RUN.
- Tag and data arrays are not reset.

## Structure
- mem_common gets:
  - t_ic_state enum (RUN, MISS_REQ, MISS_WAIT, FILL);
  - IC_OFF_W;
  - helper functions ic_idx(addr, NUM_SETS) and ic_tag(addr, NUM_SETS).
- t_mem_req, t_mem_rsp, CL_SZ_WORDS and t_word are used unchanged.
- One sub-module, sat_counter (parameter W, ports clk/reset/inc/count), instantiated twice.
- Tag and data arrays stay inline as flop/array storage.
- SIMULATION-only MEMLOG prints on FB request, FB response, mem request and mem response, plus the __addr_inst field as in the existing response type.

## Test plan
- Cold miss:
  - Stimulus: after reset, request addr 0x100, id 3.
  - Expect: ic_mem_req addr 0x100 id 3 one cycle later.
  - Mem returns W[i]=0x1000+i at cycle N+5.
  - Expect: ic_fb_rsp id 3 with that data at N+6, miss_cnt=1.
- Hit stream:
  - Stimulus: re-request 0x104, then 0x108, back-to-back.
  - Expect: two responses in consecutive cycles with the same line, hit_cnt=2, rdy high throughout.
- Conflict:
  - Stimulus: with NUM_SETS=4 and 64-byte lines, fill 0x000, then request 0x100 (same index, different tag).
  - Expect: miss and refill; a re-request of 0x000 misses again.
- Flush:
  - Stimulus: pulse ic_flush after the 0x100 fill.
  - Expect: rdy low during the pulse; the next request to 0x100 misses.
  - Stimulus: flush during MISS_WAIT.
  - Expect: the response is still delivered, and a re-request misses.
- Reset mid-miss:
  - Stimulus: assert reset in MISS_WAIT, release, then inject a stray mem response.
  - Expect: no ic_fb_rsp, state RUN, counters 0.
- Saturation:
  - Stimulus: CNT_W=3, issue 10 hits.
  - Expect: hit_cnt holds at 7.

Source files
------------

// File: rtl/mem_common.sv
// mem_common: shared memory request/response types and icache address helpers
package mem_common;
  localparam int CL_SZ_WORDS = 16;
  localparam int IC_OFF_W = $clog2(CL_SZ_WORDS * 4);
  typedef logic [31:0] t_word;
  typedef struct packed {
    t_word [CL_SZ_WORDS-1:0] W;
  } t_cl;
  typedef struct packed {
    logic        valid;
    logic [3:0]  id;
    logic [31:0] addr;
  } t_mem_req;
  typedef struct packed {
    logic        valid;
    logic [3:0]  id;
    t_cl         data;
    logic [31:0] __addr_inst;
  } t_mem_rsp;
  typedef enum logic [1:0] {RUN, MISS_REQ, MISS_WAIT, FILL} t_ic_state;
  function automatic logic [31:0] ic_idx(input logic [31:0] addr, input int num_sets);
    return (addr >> IC_OFF_W) & 32'(num_sets - 1);
  endfunction
  function automatic logic [31:0] ic_tag(input logic [31:0] addr, input int num_sets);
    return (addr >> IC_OFF_W) / 32'(num_sets);
  endfunction
endpackage

// File: rtl/icache_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped instruction cache with blocking single-miss refill
module icache_dm
  import mem_common::*;
#(
  parameter int NUM_SETS = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  t_mem_req         fb_ic_req_nnn,
  output logic             ic_fb_rdy_nnn,
  output t_mem_rsp         ic_fb_rsp_nnn,
  output t_mem_req         ic_mem_req_nnn,
  input  t_mem_rsp         mem_ic_rsp_nnn,
  input  logic             ic_flush_nnn,
  output logic [CNT_W-1:0] ic_hit_cnt,
  output logic [CNT_W-1:0] ic_miss_cnt
);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 32 - IC_OFF_W - IDX_W;
  t_ic_state state, state_nxt;
  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [NUM_SETS];
  t_cl data_q [NUM_SETS];
  logic poison;
  logic [3:0] id_q;
  logic [IDX_W-1:0] idx_q, idx;
  logic [TAG_W-1:0] tagm_q, tag;
  logic [31:0] addr_q, addr_al;
  t_mem_req mreq_q;
  t_mem_rsp rsp_q;
  logic accept, hit, miss, fill;
  logic unused_ok;
  assign unused_ok = ^{mem_ic_rsp_nnn.id, mem_ic_rsp_nnn.__addr_inst};
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= RUN;
    else state <= state_nxt;
  always_comb begin
    state_nxt = (state == RUN)       ? (miss ? MISS_REQ : RUN) :
                (state == MISS_REQ)  ? MISS_WAIT :
                (state == MISS_WAIT) ? (mem_ic_rsp_nnn.valid ? FILL : MISS_WAIT) : RUN;
  end
  always_comb begin
    idx = IDX_W'(ic_idx(fb_ic_req_nnn.addr, NUM_SETS));
    tag = TAG_W'(ic_tag(fb_ic_req_nnn.addr, NUM_SETS));
    addr_al = {fb_ic_req_nnn.addr[31:IC_OFF_W], {IC_OFF_W{1'b0}}};
    ic_fb_rdy_nnn = (state == RUN) && !ic_flush_nnn;
    accept = fb_ic_req_nnn.valid && ic_fb_rdy_nnn;
    hit = accept && valid_q[idx] && (tag_q[idx] == tag);
    miss = accept && !hit;
    fill = (state == MISS_WAIT) && mem_ic_rsp_nnn.valid;
  end
  // a flush while the refill is in flight must keep the incoming line invalid
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      valid_q <= '0;
      poison <= 1'b0;
      rsp_q <= '0;
      mreq_q <= '0;
    end else begin
      if (ic_flush_nnn) valid_q <= '0;
      else if (fill && !poison) valid_q[idx_q] <= 1'b1;
      if (ic_flush_nnn && (state == MISS_REQ || state == MISS_WAIT)) poison <= 1'b1;
      else if (state == FILL) poison <= 1'b0;
      if (hit) rsp_q <= '{1'b1, fb_ic_req_nnn.id, data_q[idx], fb_ic_req_nnn.addr};
      else if (fill) rsp_q <= '{1'b1, id_q, mem_ic_rsp_nnn.data, addr_q};
      else rsp_q.valid <= 1'b0;
      mreq_q <= miss ? '{1'b1, fb_ic_req_nnn.id, addr_al} : '{1'b0, mreq_q.id, mreq_q.addr};
    end
  always_ff @(posedge clk) begin
    if (miss) begin
      id_q <= fb_ic_req_nnn.id;
      idx_q <= idx;
      tagm_q <= tag;
      addr_q <= addr_al;
    end
    if (fill) begin
      tag_q[idx_q] <= tagm_q;
      data_q[idx_q] <= mem_ic_rsp_nnn.data;
    end
  end
  assign ic_fb_rsp_nnn = rsp_q;
  assign ic_mem_req_nnn = mreq_q;
  sat_counter #(.W(CNT_W)) u_hit_cnt (.clk(clk), .reset(reset), .inc(hit), .count(ic_hit_cnt));
  sat_counter #(.W(CNT_W)) u_miss_cnt (.clk(clk), .reset(reset), .inc(miss), .count(ic_miss_cnt));
`ifdef SIMULATION
  always @(posedge clk)
    if (!reset) begin
      if (accept) $display("MEMLOG fb_req id=%0d addr=%h", fb_ic_req_nnn.id, fb_ic_req_nnn.addr);
      if (rsp_q.valid) $display("MEMLOG fb_rsp id=%0d addr_inst=%h", rsp_q.id, rsp_q.__addr_inst);
      if (mreq_q.valid) $display("MEMLOG mem_req id=%0d addr=%h", mreq_q.id, mreq_q.addr);
      if (mem_ic_rsp_nnn.valid)
        $display("MEMLOG mem_rsp id=%0d addr_inst=%h", mem_ic_rsp_nnn.id, mem_ic_rsp_nnn.__addr_inst);
      if (state == RUN)
        assert (!mem_ic_rsp_nnn.valid) else $warning("icache_dm: unsolicited mem response ignored");
    end
`endif
endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: directed vector table plus multi-cycle corner sequences for icache_dm
module tb_icache_dm;
  import mem_common::*;
  logic clk = 1'b0;
  logic reset;
  t_mem_req fb_req;
  logic rdy;
  t_mem_rsp fb_rsp;
  t_mem_req mem_req;
  t_mem_rsp mem_rsp;
  logic flush;
  logic [2:0] hit_cnt, miss_cnt;
  int n_chk = 0, n_pass = 0;
  int exp_h = 0, exp_m = 0;
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  id;
    bit          hit;
    int          wt;
  } vec_t;
  vec_t vt[9];
  always #5 clk = ~clk;
  icache_dm #(.NUM_SETS(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .fb_ic_req_nnn(fb_req), .ic_fb_rdy_nnn(rdy),
    .ic_fb_rsp_nnn(fb_rsp), .ic_mem_req_nnn(mem_req), .mem_ic_rsp_nnn(mem_rsp),
    .ic_flush_nnn(flush), .ic_hit_cnt(hit_cnt), .ic_miss_cnt(miss_cnt)
  );
  function automatic t_cl line_of(input logic [31:0] a);
    t_cl l;
    logic [31:0] base;
    base = {a[31:6], 6'b0} << 4;
    for (int i = 0; i < CL_SZ_WORDS; i++) l.W[i] = base + 32'(i);
    return l;
  endfunction
  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic chk_cnt();
    chk("hit_cnt", 512'(hit_cnt), 512'(exp_h));
    chk("miss_cnt", 512'(miss_cnt), 512'(exp_m));
  endtask
  task automatic do_req(input logic [31:0] a, input logic [3:0] id, input bit hit, input int wt,
                        input int flush_at);
    @(negedge clk);
    chk("rdy_before_req", 512'(rdy), 512'(1));
    fb_req = '{1'b1, id, a};
    @(negedge clk);
    fb_req.valid = 1'b0;
    if (hit) begin
      exp_h = exp_h < 7 ? exp_h + 1 : 7;
      chk("hit_rsp_valid", 512'(fb_rsp.valid), 512'(1));
      chk("hit_rsp_id", 512'(fb_rsp.id), 512'(id));
      chk("hit_rsp_data", 512'(fb_rsp.data), 512'(line_of(a)));
      chk("hit_mem_req_idle", 512'(mem_req.valid), 512'(0));
      chk("hit_rdy", 512'(rdy), 512'(1));
    end else begin
      exp_m = exp_m < 7 ? exp_m + 1 : 7;
      chk("miss_rsp_idle", 512'(fb_rsp.valid), 512'(0));
      chk("mem_req_valid", 512'(mem_req.valid), 512'(1));
      chk("mem_req_id", 512'(mem_req.id), 512'(id));
      chk("mem_req_addr", 512'(mem_req.addr), 512'({a[31:6], 6'b0}));
      chk("miss_rdy_low", 512'(rdy), 512'(0));
      for (int k = 0; k < wt; k++) begin
        @(negedge clk);
        flush = (k == flush_at);
        if (k == 0) chk("mem_req_pulse", 512'(mem_req.valid), 512'(0));
      end
      @(negedge clk);
      flush = 1'b0;
      mem_rsp = '{1'b1, id, line_of(a), {a[31:6], 6'b0}};
      @(negedge clk);
      mem_rsp.valid = 1'b0;
      chk("fill_rsp_valid", 512'(fb_rsp.valid), 512'(1));
      chk("fill_rsp_id", 512'(fb_rsp.id), 512'(id));
      chk("fill_rsp_data", 512'(fb_rsp.data), 512'(line_of(a)));
      chk("fill_rdy_low", 512'(rdy), 512'(0));
      @(negedge clk);
      chk("post_fill_rdy", 512'(rdy), 512'(1));
      chk("post_fill_rsp_idle", 512'(fb_rsp.valid), 512'(0));
    end
    chk_cnt();
  endtask
  initial begin
    vt[0] = '{32'h100, 4'd3, 1'b0, 3};
    vt[1] = '{32'h104, 4'd4, 1'b1, 0};
    vt[2] = '{32'h108, 4'd5, 1'b1, 0};
    vt[3] = '{32'h000, 4'd1, 1'b0, 0};
    vt[4] = '{32'h100, 4'd2, 1'b0, 1};
    vt[5] = '{32'h000, 4'd6, 1'b0, 2};
    vt[6] = '{32'h040, 4'd7, 1'b0, 0};
    vt[7] = '{32'h07c, 4'd0, 1'b1, 0};
    vt[8] = '{32'h000, 4'd1, 1'b1, 0};
    reset = 1'b1;
    fb_req = '0;
    mem_rsp = '0;
    flush = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_rdy", 512'(rdy), 512'(1));
    chk("reset_rsp_valid", 512'(fb_rsp.valid), 512'(0));
    chk("reset_mem_req_valid", 512'(mem_req.valid), 512'(0));
    chk_cnt();
    for (int v = 0; v < 9; v++) do_req(vt[v].addr, vt[v].id, vt[v].hit, vt[v].wt, -1);
    // back-to-back hits on the line at 0x040
    @(negedge clk);
    fb_req = '{1'b1, 4'd8, 32'h044};
    @(negedge clk);
    chk("b2b_rdy0", 512'(rdy), 512'(1));
    chk("b2b_rsp0_valid", 512'(fb_rsp.valid), 512'(1));
    chk("b2b_rsp0_id", 512'(fb_rsp.id), 512'(8));
    fb_req = '{1'b1, 4'd9, 32'h048};
    @(negedge clk);
    fb_req.valid = 1'b0;
    chk("b2b_rdy1", 512'(rdy), 512'(1));
    chk("b2b_rsp1_valid", 512'(fb_rsp.valid), 512'(1));
    chk("b2b_rsp1_id", 512'(fb_rsp.id), 512'(9));
    chk("b2b_rsp1_data", 512'(fb_rsp.data), 512'(line_of(32'h040)));
    exp_h = exp_h + 2 > 7 ? 7 : exp_h + 2;
    @(negedge clk);
    chk("b2b_rsp_idle", 512'(fb_rsp.valid), 512'(0));
    chk_cnt();
    // flush pulse while idle
    flush = 1'b1;
    #1 chk("flush_rdy_low", 512'(rdy), 512'(0));
    @(negedge clk);
    flush = 1'b0;
    #1 chk("flush_rdy_back", 512'(rdy), 512'(1));
    do_req(32'h040, 4'd10, 1'b0, 0, -1);
    do_req(32'h040, 4'd11, 1'b1, 0, -1);
    // flush during MISS_WAIT: data still returned, line left invalid
    do_req(32'h200, 4'd12, 1'b0, 3, 1);
    do_req(32'h200, 4'd13, 1'b0, 0, -1);
    do_req(32'h200, 4'd14, 1'b1, 0, -1);
    // reset in MISS_WAIT, then a stray mem response
    @(negedge clk);
    fb_req = '{1'b1, 4'd9, 32'h300};
    @(negedge clk);
    fb_req.valid = 1'b0;
    chk("rst_mid_mem_req", 512'(mem_req.valid), 512'(1));
    @(negedge clk);
    chk("rst_mid_wait_rdy", 512'(rdy), 512'(0));
    reset = 1'b1;
    #1 chk("rst_async_rdy", 512'(rdy), 512'(1));
    exp_h = 0;
    exp_m = 0;
    chk_cnt();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    mem_rsp = '{1'b1, 4'd9, line_of(32'h300), 32'h300};
    @(negedge clk);
    mem_rsp.valid = 1'b0;
    chk("stray_rsp_idle0", 512'(fb_rsp.valid), 512'(0));
    chk("stray_rdy", 512'(rdy), 512'(1));
    @(negedge clk);
    chk("stray_rsp_idle1", 512'(fb_rsp.valid), 512'(0));
    chk("stray_mem_req_idle", 512'(mem_req.valid), 512'(0));
    chk_cnt();
    // hit counter saturation
    do_req(32'h0c0, 4'd2, 1'b0, 0, -1);
    for (int h = 0; h < 10; h++) do_req(32'h0c0 + 32'(4 * h), 4'(h), 1'b1, 0, -1);
    chk("hit_cnt_saturated", 512'(hit_cnt), 512'(7));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
